// File: rtl/dvi_pixel_feeder_pkg.sv
// Shared graphics definitions: pixel/word widths and DVI word packing helpers.
package dvi_pixel_feeder_pkg;

    localparam int PIXEL_W = 24;
    localparam int WORD_W  = 64;

    // Two-pixel DVI word: pixel0 lands in the upper half (offset 0), pixel1 in the lower.
    function automatic logic [WORD_W-1:0] pack_word(input logic [PIXEL_W-1:0] p0,
                                                    input logic [PIXEL_W-1:0] p1);
        return {8'h00, p0, 8'h00, p1};
    endfunction

    // Word shown when nothing valid is held: the fill colour in both slots.
    function automatic logic [WORD_W-1:0] fill_word(input logic [PIXEL_W-1:0] color);
        return pack_word(color, color);
    endfunction

endpackage

// File: rtl/dvi_word_fifo.sv
// DEPTH x 64-bit synchronous FIFO with show-ahead read data, count, full and empty.
module dvi_word_fifo
    import dvi_pixel_feeder_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WORD_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [WORD_W-1:0]        pop_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              push_en;
    logic              pop_en;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_en    = push_i && !full_o;
    assign pop_en     = pop_i && !empty_o;

    // Next pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_en && !pop_en)      count_d = count_q + 1'b1;
        else if (!push_en && pop_en) count_d = count_q - 1'b1;
    end

    // Control state: pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dvi_pixel_feeder.sv
// Packs 24-bit pixels in pairs into 64-bit DVI words, buffers them and presents
// a show-ahead word that advances on each DVI request.
module dvi_pixel_feeder
    import dvi_pixel_feeder_pkg::*;
#(
    parameter int                 DEPTH      = 16,
    parameter logic [PIXEL_W-1:0] FILL_COLOR = 24'h000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pix_valid,
    input  logic [PIXEL_W-1:0]       pix_data,
    output logic                     pix_ready,
    input  logic                     request,
    output logic [WORD_W-1:0]        data,
    output logic [$clog2(DEPTH)+1:0] level,
    output logic                     underflow,
    input  logic                     clear_underflow
);

    localparam int                LW     = $clog2(DEPTH) + 2;
    localparam logic [WORD_W-1:0] FILL_W = fill_word(FILL_COLOR);

    logic                     half_q, half_d;
    logic [PIXEL_W-1:0]       hi_q, hi_d;
    logic [WORD_W-1:0]        data_q, data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     underflow_q, underflow_d;

    logic                     handshake;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic [WORD_W-1:0]        fifo_rdata;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;

    // Second pixel of a pair only goes in when the FIFO has room right now.
    assign pix_ready = !half_q || !fifo_full;
    assign handshake = pix_valid && pix_ready;

    dvi_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (pack_word(hi_q, pix_data)),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Packer: hold the first pixel, push the pair when its partner arrives.
    always_comb begin
        half_d    = half_q;
        hi_d      = hi_q;
        fifo_push = 1'b0;
        if (handshake) begin
            if (!half_q) begin
                hi_d   = pix_data;
                half_d = 1'b1;
            end else begin
                fifo_push = 1'b1;
                half_d    = 1'b0;
            end
        end
    end

    // Output stage and underflow tracking, evaluated in priority order.
    always_comb begin
        data_d      = data_q;
        out_valid_d = out_valid_q;
        underflow_d = underflow_q;
        fifo_pop    = 1'b0;
        if (clear_underflow) underflow_d = 1'b0;
        if (request) begin
            if (out_valid_q) begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_rdata;
                end else begin
                    data_d      = FILL_W;
                    out_valid_d = 1'b0;
                end
            end else begin
                // Set wins over a coincident clear.
                underflow_d = 1'b1;
            end
        end else if (!out_valid_q && !fifo_empty) begin
            fifo_pop    = 1'b1;
            data_d      = fifo_rdata;
            out_valid_d = 1'b1;
        end
    end

    // Control and output registers; reset discards any half pair and the held word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            half_q      <= 1'b0;
            data_q      <= FILL_W;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            half_q      <= half_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            underflow_q <= underflow_d;
        end
    end

    // First-pixel holding register; only meaningful while half_q is set.
    always_ff @(posedge clock) begin
        hi_q <= hi_d;
    end

    assign data      = data_q;
    assign underflow = underflow_q;
    assign level     = {1'b0, fifo_count} + {{(LW-1){1'b0}}, out_valid_q};

endmodule
